// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-master arbiter for the single-port unified RAM. It sits
//                between the CPU memory path and a secondary bus master
//                (DMA / program loader). Grants are registered and decided by
//                round-robin priority on ties. An optional hold limit stops
//                either master from starving the other.
//
//  Build option: ARB_HOLD_LIMIT_EN
//                Defined   -> an owner that keeps requesting while the other
//                             master waits is preempted after MAX_HOLD
//                             consecutive granted cycles.
//                Undefined -> no preemption; the owner keeps the port until
//                             it drops its request (hold counter omitted).
//
//  Parameters  : MAX_HOLD (1..255) consecutive-grant limit, default 8
//
//  Ports       : clk                      system clock, rising edge
//                clr                      synchronous active-high reset
//                cpu_req/we/addr/wdata    CPU request, write enable, address,
//                                         write data
//                cpu_gnt, cpu_rdata       CPU grant and read data (0 when not
//                                         granted)
//                dma_req/we/addr/wdata    second master request side
//                dma_gnt, dma_rdata       second master grant and read data
//                mem_addr, mem_write,     RAM address, write strobe and write
//                mem_datain               data (all 0 while idle)
//                mem_dataout              RAM combinational read data
//                owner                    00 idle, 01 CPU, 10 DMA
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        clr,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout,

    output logic [1:0]  owner
);

    // ------------------------------------------------------------------------
    // Elaboration-time legality check on the hold limit
    // ------------------------------------------------------------------------
    generate
        if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_max_hold_check
            $error("mem_arbiter: MAX_HOLD must be in 1..255");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding doubles as the owner code, so the register drives the
    // grants and the owner port with no decode stage in between.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWN_CPU = 2'b01,
        ST_OWN_DMA = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // 1 means the DMA side held the port most recently, so the CPU wins the
    // next tie. Reset value gives the CPU the first contested grant.
    logic   r_last_dma;

    // High when the current owner has used up its turn (always low when the
    // hold limit is compiled out).
    logic   w_hold_expired;

    // ------------------------------------------------------------------------
    // State register and round-robin history
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_last_dma <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                if (w_next_state == ST_OWN_CPU) begin
                    r_last_dma <= 1'b0;
                end else if (w_next_state == ST_OWN_DMA) begin
                    r_last_dma <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    // ------------------------------------------------------------------------
    // Consecutive-grant counter: cleared on every ownership change, counts
    // while the same owner keeps the port, saturates at MAX_HOLD.
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_hold_max  = 8'(MAX_HOLD);
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_hold_cnt <= 8'd0;
        end else if (w_next_state != r_state) begin
            r_hold_cnt <= 8'd0;
        end else if ((r_state != ST_IDLE) && (r_hold_cnt != c_hold_max)) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    // Compare with >= rather than == so that a requester arriving after the
    // counter has already saturated still gets the port at the next edge.
    assign w_hold_expired = (r_hold_cnt >= c_hold_last);
`else
    assign w_hold_expired = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req && dma_req) begin
                    w_next_state = r_last_dma ? ST_OWN_CPU : ST_OWN_DMA;
                end else if (cpu_req) begin
                    w_next_state = ST_OWN_CPU;
                end else if (dma_req) begin
                    w_next_state = ST_OWN_DMA;
                end
            end

            ST_OWN_CPU: begin
                if (!cpu_req) begin
                    w_next_state = dma_req ? ST_OWN_DMA : ST_IDLE;
                end else if (dma_req && w_hold_expired) begin
                    w_next_state = ST_OWN_DMA;
                end
            end

            ST_OWN_DMA: begin
                if (!dma_req) begin
                    w_next_state = cpu_req ? ST_OWN_CPU : ST_IDLE;
                end else if (cpu_req && w_hold_expired) begin
                    w_next_state = ST_OWN_CPU;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grants and owner come straight from the state register.
    // ------------------------------------------------------------------------
    assign cpu_gnt = (r_state == ST_OWN_CPU);
    assign dma_gnt = (r_state == ST_OWN_DMA);
    assign owner   = r_state;

    // ------------------------------------------------------------------------
    // Datapath mux on the current owner. The write strobe is qualified by the
    // live request so the trailing granted cycle after a release cannot write.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_addr   = 32'd0;
        mem_datain = 32'd0;
        mem_write  = 1'b0;
        case (r_state)
            ST_OWN_CPU: begin
                mem_addr   = cpu_addr;
                mem_datain = cpu_wdata;
                mem_write  = cpu_req & cpu_we;
            end
            ST_OWN_DMA: begin
                mem_addr   = dma_addr;
                mem_datain = dma_wdata;
                mem_write  = dma_req & dma_we;
            end
            default: begin
                mem_addr   = 32'd0;
                mem_datain = 32'd0;
                mem_write  = 1'b0;
            end
        endcase
    end

    assign cpu_rdata = cpu_gnt ? mem_dataout : 32'd0;
    assign dma_rdata = dma_gnt ? mem_dataout : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter (MAX_HOLD = 4). Each
//                stimulus step drives the inputs for one clock cycle and
//                queues the outputs expected during that cycle; a monitor on
//                the falling edge pops and compares. A small RAM model closes
//                the memory loop. Expectations follow ARB_HOLD_LIMIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;
    localparam logic [31:0] N = 32'h0;

    logic        clk;
    logic        clr;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, dma_gnt, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_datain, mem_dataout;
    logic [1:0]  owner;

    typedef struct {
        int          id;
        logic        cg;
        logic        dg;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic [31:0] crd;
        logic [31:0] drd;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    // RAM model: combinational read, write at the rising edge
    logic [31:0] ram [0:1023];
    logic        ram_clear;

    assign mem_dataout = ram[mem_addr[11:2]];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        end else if (mem_write) begin
            ram[mem_addr[11:2]] <= mem_datain;
        end
    end

    mem_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rdata   (dma_rdata),
        .mem_addr    (mem_addr),
        .mem_write   (mem_write),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout),
        .owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected in that same cycle
    task automatic step(
        input logic k_clr,
        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic ecg, input logic edg, input logic emw,
        input logic [31:0] ema, input logic [31:0] emd,
        input logic [31:0] ecrd, input logic [31:0] edrd);
        exp_t e;
        @(posedge clk);
        #1;
        ram_clear = 1'b0;
        clr       = k_clr;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        dma_req   = dr;
        dma_we    = dw;
        dma_addr  = da;
        dma_wdata = dd;
        step_id++;
        e.id  = step_id;
        e.cg  = ecg;
        e.dg  = edg;
        e.mw  = emw;
        e.ma  = ema;
        e.md  = emd;
        e.crd = ecrd;
        e.drd = edrd;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            n_tests++;
            if ({cpu_gnt, dma_gnt, owner, mem_write, mem_addr, mem_datain, cpu_rdata, dma_rdata} !==
                {m_e.cg, m_e.dg, m_e.dg, m_e.cg, m_e.mw, m_e.ma, m_e.md, m_e.crd, m_e.drd}) begin
                n_fail++;
                $display("FAIL step%0d: got cg=%b dg=%b own=%b mw=%b ma=%h md=%h crd=%h drd=%h, expected cg=%b dg=%b own=%b%b mw=%b ma=%h md=%h crd=%h drd=%h",
                         m_e.id, cpu_gnt, dma_gnt, owner, mem_write, mem_addr, mem_datain, cpu_rdata, dma_rdata,
                         m_e.cg, m_e.dg, m_e.dg, m_e.cg, m_e.mw, m_e.ma, m_e.md, m_e.crd, m_e.drd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ram_clear = 1'b1;
        clr       = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        dma_req   = 1'b1;
        dma_we    = 1'b0;
        dma_addr  = 32'h0;
        dma_wdata = 32'h0;

        // Reset held two edges with both masters requesting: all outputs idle
        step(H, H,L,N,N, H,L,N,N, L,L,L,N,N,N,N);
        step(L, H,L,N,N, H,L,N,N, L,L,L,N,N,N,N);
        // Tie out of reset goes to the CPU; its write strobes for one cycle
        step(L, H,H,32'h40,32'hDEADBEEF, H,H,32'h80,32'h11111111, H,L,H,32'h40,32'hDEADBEEF,N,N);
        // CPU reads back what it wrote; DMA sees zero
        step(L, H,L,32'h40,N, H,H,32'h80,32'h11111111, H,L,L,32'h40,N,32'hDEADBEEF,N);
        // CPU drops req: trailing granted cycle, no write
        step(L, L,L,N,N, H,H,32'h80,32'h11111111, H,L,L,N,N,N,N);
        // Handoff to DMA with no idle gap
        step(L, L,L,N,N, H,H,32'h80,32'h11111111, L,H,H,32'h80,32'h11111111,N,N);
        step(L, L,L,N,N, H,L,32'h80,N, L,H,L,32'h80,N,N,32'h11111111);
        // DMA drops req with we still high: write must be gated
        step(L, L,L,N,N, L,H,32'h40,32'hCAFEF00D, L,H,L,32'h40,32'hCAFEF00D,N,32'hDEADBEEF);
        step(L, L,L,N,N, L,L,N,N, L,L,L,N,N,N,N);
        // DMA write burst interrupted by reset
        step(L, L,L,N,N, H,H,32'h100,32'hA5A5A5A5, L,L,L,N,N,N,N);
        step(L, L,L,N,N, H,H,32'h100,32'hA5A5A5A5, L,H,H,32'h100,32'hA5A5A5A5,N,N);
        step(H, L,L,N,N, H,H,32'h104,32'h5A5A5A5A, L,H,H,32'h104,32'h5A5A5A5A,N,N);
        step(L, H,L,32'h104,N, H,H,32'h108,32'h12345678, L,L,L,N,N,N,N);
        // Round-robin history was reset: CPU wins; write in the clr cycle landed
        step(L, H,L,32'h104,N, H,H,32'h108,32'h12345678, H,L,L,32'h104,N,32'h5A5A5A5A,N);
        // CPU keeps requesting while DMA waits; 0x40 still holds the first write
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, H,L,L,32'h40,N,32'hDEADBEEF,N);
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, H,L,L,32'h40,N,32'hDEADBEEF,N);
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, H,L,L,32'h40,N,32'hDEADBEEF,N);
`ifdef ARB_HOLD_LIMIT_EN
        // Fifth cycle: CPU preempted after exactly four granted cycles
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, L,H,H,32'h108,32'h12345678,N,N);
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, L,H,H,32'h108,32'h12345678,N,32'h12345678);
        step(L, L,L,N,N, L,L,N,N, L,H,L,N,N,N,N);
`else
        // No preemption: CPU keeps the port
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, H,L,L,32'h40,N,32'hDEADBEEF,N);
        step(L, H,L,32'h40,N, H,H,32'h108,32'h12345678, H,L,L,32'h40,N,32'hDEADBEEF,N);
        step(L, L,L,N,N, L,L,N,N, H,L,L,N,N,N,N);
`endif
        // Both re-request from idle: the master that did not own last wins
        step(L, H,L,32'h40,N, H,L,32'h80,N, L,L,L,N,N,N,N);
`ifdef ARB_HOLD_LIMIT_EN
        step(L, H,L,32'h40,N, H,L,32'h80,N, H,L,L,32'h40,N,32'hDEADBEEF,N);
`else
        step(L, H,L,32'h40,N, H,L,32'h80,N, L,H,L,32'h80,N,N,32'h11111111);
`endif

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port unified RAM between the multicycle CPU (instruction fetch and load/store) and a secondary bus master (DMA / program loader). It sits between the CPU's memory-address/data path and the RAM instance. It issues registered grants with round-robin priority and an optional hold-limit that prevents either master from starving the other. The CPU stalls its controller while its request is pending without a grant.

## Interface
Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles for one owner while the other requests (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU requests the memory port.
- cpu_we  input  1  CPU write enable (valid with cpu_req).
- cpu_addr  input  32  CPU byte address.
- cpu_wdata  input  32  CPU write data.
- cpu_gnt  output  1  CPU owns the port this cycle.
- cpu_rdata  output  32  read data to CPU; 0 when cpu_gnt low.
- dma_req, dma_we, dma_addr[31:0], dma_wdata[31:0]  input  same meanings for master 1.
- dma_gnt  output  1  master 1 owns the port this cycle.
- dma_rdata  output  32  read data to master 1; 0 when dma_gnt low.
- mem_addr  output  32  RAM address.
- mem_write  output  1  RAM write strobe.
- mem_datain  output  32  RAM write data.
- mem_dataout  input  32  RAM read data (combinational read).
- owner  output  2  00 idle, 01 CPU, 10 DMA.

## Operation
- States: IDLE, OWN_CPU, OWN_DMA. State register drives cpu_gnt, dma_gnt, and owner directly; at most one grant is high in any cycle.
- IDLE: if exactly one req is high, move to that owner. If both are high, grant the master that did not own last (last_owner bit; reset value selects CPU first). If neither is high, stay.
- OWN_x: if req_x is low, release. Go to the other owner if its req is high, else IDLE. If req_x is high, stay, unless the hold-limit condition applies (see Configuration).
- Datapath is a combinational mux on the current owner.
  - mem_addr, mem_datain: owner's addr/wdata. Both are 0 in IDLE.
  - mem_write = gnt_x & req_x & we_x. No write occurs in a granted cycle where req has already dropped.
  - rdata_x = gnt_x ? mem_dataout : 0.
- hold_cnt (8-bit) is cleared on every ownership change and increments each cycle the same owner keeps the grant. It saturates at MAX_HOLD.
- last_owner updates on every entry into OWN_CPU or OWN_DMA.

## Timing
- Reset: state IDLE, cpu_gnt=0, dma_gnt=0, owner=00, mem_write=0, mem_addr=0, mem_datain=0, both rdata=0, hold_cnt=0, last_owner selects CPU next.
- Grant latency: req sampled high at edge N gives gnt high from N+1. The first access completes in the cycle after the request.
- Release latency: req low at edge M gives gnt low from M+1. The cycle between is a dead cycle (write gated).
- Handoff: one edge, no idle cycle between owners, no overlap.
- Reads: data is valid in the same cycle gnt and addr are presented. The requester captures it at the following edge.
- Writes commit at the rising edge ending a cycle with mem_write high.
- Reset mid-access: clr high at an edge forces IDLE and suppresses mem_write from the next cycle. A write in the cycle where clr is sampled still commits if mem_write was high.
- Simultaneous req rise from IDLE: round-robin picks; the loser is granted no later than on the winner's release, or at hold limit.

## Configuration
- ARB_HOLD_LIMIT_EN defined: in OWN_x with req_x high, the other req high, and hold_cnt == MAX_HOLD-1, ownership transfers at the next edge. The preempted master sees gnt drop and must hold its req and stall.
- Undefined: no preemption. The owner keeps the port until it drops req. The hold_cnt logic is omitted.

## Test plan
- Reset: assert clr 2 cycles with both reqs high -> all outputs 0, owner=00. First grant after release goes to CPU.
- CPU alone: cpu_req=1, cpu_we=1, addr=0x40, wdata=0xDEADBEEF at edge N -> cpu_gnt=1 from N+1, mem_write=1 one cycle. A following read of 0x40 returns cpu_rdata=0xDEADBEEF, and dma_rdata=0.
- Contention round-robin: both reqs rise together from reset -> CPU granted. CPU drops req -> dma_gnt=1 at the next edge with no gap. Both re-request after DMA releases -> CPU is granted.
- Dead-cycle gating: owner drops req with we still high -> mem_write=0 in the trailing granted cycle, and RAM is unchanged.
- Hold limit (macro on, MAX_HOLD=4): CPU holds req continuously while DMA requests -> CPU granted exactly 4 cycles, then dma_gnt. With the macro off, the CPU keeps the grant indefinitely.
- Reset mid-burst: clr during OWN_DMA write burst -> next cycle IDLE, mem_write=0, owner=00.
